trap_seq_ctrl: RTL and testbench
================================

TRAP_SEQ_CTRL -- requirements
Module: trap_seq_ctrl

Interface
REQ-001 Parameter: DRAIN_MAX, default 16, max cycles spent in DRAIN when TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN is defined (range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 exc_valid  in  1  exception reported by the pipeline this cycle (exception code bit 5 set).
REQ-005 exc_code  in  6  exception code; bits [4:0] = cause.
REQ-006 exc_pc  in  32  PC of the faulting instruction.
REQ-007 mret_req  in  1  MRET reached the commit point.
REQ-008 br_jmp_flag  in  1  branch/jump taken.
REQ-009 br_target  in  32  branch/jump target.
REQ-010 mtvec  in  32  trap vector CSR value.
REQ-011 mepc_in  in  32  current mepc CSR value.
REQ-012 mem_busy  in  1  data-memory access outstanding.
REQ-013 flush  out  1  one-cycle pulse; clears IF/ID/EX pipeline registers.
REQ-014 stall_fetch  out  1  hold fetch and decode (drives exception_stalled).
REQ-015 redirect_valid  out  1  one-cycle pulse; fetch loads redirect_pc.
REQ-016 redirect_pc  out  32  new fetch PC, valid with redirect_valid.
REQ-017 csr_trap_we  out  1  one-cycle pulse; write csr_mepc/csr_mcause.
REQ-018 csr_mepc  out  32  captured exc_pc.
REQ-019 csr_mcause  out  5  captured exc_code[4:0].
REQ-020 mret_done  out  1  one-cycle pulse on MRET redirect.
REQ-021 busy  out  1  high whenever state is not IDLE.
REQ-022 drain_timeout  out  1  sticky drain-watchdog flag.

Function
REQ-023 States: IDLE, FLUSH, DRAIN, COMMIT, REDIRECT; all outputs registered.
REQ-024 Priority in IDLE: exc_valid > mret_req > br_jmp_flag.
REQ-025 IDLE, exc_valid at T: capture exc_pc/exc_code; T+1 state FLUSH, flush=1, stall_fetch=1.
REQ-026 FLUSH -> DRAIN unconditionally; stall_fetch held 1 from FLUSH through REDIRECT.
REQ-027 DRAIN: remain while mem_busy=1; mem_busy=0 -> COMMIT next cycle.
REQ-028 COMMIT: csr_trap_we=1 for one cycle with csr_mepc/csr_mcause = captured values; -> REDIRECT.
REQ-029 REDIRECT (trap): redirect_valid=1, redirect_pc={mtvec[31:2],2'b00}; -> IDLE; stall_fetch=0 in IDLE.
REQ-030 IDLE, mret_req (no exc_valid) at T: T+1 FLUSH with flush=1; T+2 REDIRECT with redirect_valid=1, redirect_pc=mepc_in sampled at T+1, mret_done=1; T+3 IDLE. MRET skips DRAIN/COMMIT.
REQ-031 IDLE, br_jmp_flag only at T: T+1 flush=1, redirect_valid=1, redirect_pc=br_target; state stays IDLE; busy stays 0.
REQ-032 exc_valid, mret_req, br_jmp_flag ignored in all non-IDLE states (masked, not queued).
REQ-033 Back-to-back: an event in the IDLE cycle immediately after REDIRECT is accepted normally.
REQ-034 csr_mepc/csr_mcause hold last captured value until next exception capture.

Reset
REQ-035 rst asserted at any time, including mid-sequence: state IDLE immediately, all outputs 0, captured registers 0, drain counter 0, drain_timeout 0.
REQ-036 First event sampled on the first rising edge after rst deasserts.

Configuration
REQ-037 Macro TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN defined: 8-bit counter cleared on DRAIN entry, increments each DRAIN cycle; on reaching DRAIN_MAX with mem_busy=1, proceed to COMMIT and set drain_timeout=1 (cleared only by rst).
REQ-038 Macro undefined: no counter; DRAIN waits indefinitely; drain_timeout tied 0.

Verification
REQ-039 exc_valid=1, exc_code=6'h22, exc_pc=0x100, mtvec=0x8000_0003, mem_busy=0 -> flush T+1, csr_trap_we T+3 (mepc=0x100, mcause=2), redirect_pc=0x8000_0000 at T+4, busy T+1..T+4.
REQ-040 mret_req=1, mepc_in=0x244 -> flush T+1, redirect_valid+mret_done T+2 with redirect_pc=0x244, no csr_trap_we.
REQ-041 br_jmp_flag=1 and exc_valid=1 same cycle, br_target=0x40 -> trap sequence only; redirect_pc never 0x40.
REQ-042 Exception with mem_busy held 5 cycles -> DRAIN 5 cycles, csr_trap_we the cycle after mem_busy falls; with macro and DRAIN_MAX=4, mem_busy stuck 1 -> COMMIT after 4 DRAIN cycles, drain_timeout=1.
REQ-043 rst pulsed in DRAIN -> all outputs 0 same cycle; subsequent br_jmp_flag redirects normally.

Source files
------------

// File: rtl/trap_seq_ctrl.sv
// Trap/MRET/branch redirect sequencer; TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN adds a DRAIN watchdog.
// Latency: branch redirect 1 cycle, MRET redirect 2 cycles, trap redirect 4 + extra DRAIN cycles.
// Backpressure: events outside IDLE are dropped; mem_busy holds the sequence in DRAIN.
module trap_seq_ctrl #(
    parameter int DRAIN_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [5:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        mret_req,
    input  logic        br_jmp_flag,
    input  logic [31:0] br_target,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_in,
    input  logic        mem_busy,
    output logic        flush,
    output logic        stall_fetch,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        csr_trap_we,
    output logic [31:0] csr_mepc,
    output logic [4:0]  csr_mcause,
    output logic        mret_done,
    output logic        busy,
    output logic        drain_timeout
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FLUSH    = 3'd1,
        DRAIN    = 3'd2,
        COMMIT   = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t state;
    logic   is_mret;

    generate
        if (DRAIN_MAX < 2 || DRAIN_MAX > 255) begin : g_bad_drain_max
            $error("trap_seq_ctrl: DRAIN_MAX must be in 2..255");
        end
    endgenerate

    // Bit 5 of the code only qualifies exc_valid upstream; mtvec mode bits are ignored.
    logic unused_bits;
    assign unused_bits = ^{exc_code[5], mtvec[1:0]};

`ifdef TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX);
    logic [7:0] drain_cnt;
`else
    assign drain_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            is_mret        <= 1'b0;
            flush          <= 1'b0;
            stall_fetch    <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            csr_trap_we    <= 1'b0;
            csr_mepc       <= '0;
            csr_mcause     <= '0;
            mret_done      <= 1'b0;
            busy           <= 1'b0;
`ifdef TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN
            drain_cnt      <= '0;
            drain_timeout  <= 1'b0;
`endif
        end else begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            csr_trap_we    <= 1'b0;
            mret_done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (exc_valid) begin
                        state       <= FLUSH;
                        is_mret     <= 1'b0;
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        busy        <= 1'b1;
                        csr_mepc    <= exc_pc;
                        csr_mcause  <= exc_code[4:0];
                    end else if (mret_req) begin
                        state       <= FLUSH;
                        is_mret     <= 1'b1;
                        flush       <= 1'b1;
                        stall_fetch <= 1'b1;
                        busy        <= 1'b1;
                    end else if (br_jmp_flag) begin
                        // Branches redirect in one shot without leaving IDLE.
                        flush          <= 1'b1;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= br_target;
                    end
                end
                FLUSH: begin
                    if (is_mret) begin
                        state          <= REDIRECT;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= mepc_in;
                        mret_done      <= 1'b1;
                    end else begin
                        state <= DRAIN;
`ifdef TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN
                        drain_cnt <= '0;
`endif
                    end
                end
                DRAIN: begin
`ifdef TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN
                    drain_cnt <= drain_cnt + 8'd1;
                    if (!mem_busy) begin
                        state       <= COMMIT;
                        csr_trap_we <= 1'b1;
                    end else if (drain_cnt + 8'd1 == DRAIN_LAST) begin
                        state         <= COMMIT;
                        csr_trap_we   <= 1'b1;
                        drain_timeout <= 1'b1;
                    end
`else
                    if (!mem_busy) begin
                        state       <= COMMIT;
                        csr_trap_we <= 1'b1;
                    end
`endif
                end
                COMMIT: begin
                    state          <= REDIRECT;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= {mtvec[31:2], 2'b00};
                end
                REDIRECT: begin
                    state       <= IDLE;
                    stall_fetch <= 1'b0;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    stall_fetch <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Randomized bench for trap_seq_ctrl: a cycle-level event model feeds a scoreboard queue.
module tb_trap_seq_ctrl;
    localparam int DMAX = 4;
    localparam int NCYC = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_req, br_jmp_flag, mem_busy;
    logic [5:0]  exc_code;
    logic [31:0] exc_pc, br_target, mtvec, mepc_in;
    logic        flush, stall_fetch, redirect_valid, csr_trap_we, mret_done, busy, drain_timeout;
    logic [31:0] redirect_pc, csr_mepc;
    logic [4:0]  csr_mcause;

    trap_seq_ctrl #(.DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
        .mret_req(mret_req), .br_jmp_flag(br_jmp_flag), .br_target(br_target),
        .mtvec(mtvec), .mepc_in(mepc_in), .mem_busy(mem_busy),
        .flush(flush), .stall_fetch(stall_fetch),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .csr_trap_we(csr_trap_we), .csr_mepc(csr_mepc), .csr_mcause(csr_mcause),
        .mret_done(mret_done), .busy(busy), .drain_timeout(drain_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        fl, rv, we, md, to;
        logic [31:0] pc, mepc;
        logic [4:0]  mc;
    } exp_t;

    exp_t q[$];
    bit   exp_busy [0:NCYC-1];
    int   cyc = 0;
    int   free_at = 0, drain_lo = 0, drain_hi = -1, busy_hi = -1;
    bit   to_flag = 1'b0, mon_en = 1'b0;
    int   checks = 0, errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    function automatic exp_t mk(input int c, input logic fl, rv, we, md, to,
                                input logic [31:0] pc, mepc, input logic [4:0] mc);
        exp_t e;
        e.cyc = c; e.fl = fl; e.rv = rv; e.we = we; e.md = md; e.to = to;
        e.pc = pc; e.mepc = mepc; e.mc = mc;
        return e;
    endfunction

    function automatic logic [95:0] all_outs();
        return 96'({flush, stall_fetch, redirect_valid, redirect_pc, csr_trap_we,
                    csr_mepc, csr_mcause, mret_done, busy, drain_timeout});
    endfunction

    // Monitor: every pulse the DUT shows must match the oldest expected event.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            check("busy_stall", 96'({busy, stall_fetch}), 96'({2{exp_busy[cyc]}}));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                checks++; errors++;
                $display("FAIL missing_event cyc=%0d got=none expected_at=%0d", cyc, e.cyc);
            end
            if (flush || redirect_valid || csr_trap_we || mret_done) begin
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    check("unexpected_event", 96'({flush, redirect_valid, csr_trap_we, mret_done}), 96'(0));
                end else begin
                    e = q.pop_front();
                    check("event_pulses", 96'({flush, redirect_valid, csr_trap_we, mret_done}),
                          96'({e.fl, e.rv, e.we, e.md}));
                    if (e.rv) check("redirect_pc", 96'(redirect_pc), 96'(e.pc));
                    if (e.we) begin
                        check("csr_values", 96'({csr_mepc, csr_mcause}), 96'({e.mepc, e.mc}));
                        check("drain_timeout", 96'(drain_timeout), 96'(e.to));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; the reference model decides what the cycle's event produces.
    task automatic step(input logic e, input logic m, input logic b, input logic [5:0] code,
                        input logic [31:0] epc, input logic [31:0] tgt, input logic [31:0] mtv,
                        input logic [31:0] mep, input int n);
        int   d;
        logic to;
        @(posedge clk); #1;
        exc_valid = e; mret_req = m; br_jmp_flag = b;
        exc_code = code; exc_pc = epc; br_target = tgt;
        if (cyc >= free_at) begin
            mtvec = mtv; mepc_in = mep;
            if (e) begin
                d = n + 1; to = 1'b0;
`ifdef TRAP_SEQ_CTRL_DRAIN_TIMEOUT_EN
                if (n >= DMAX) begin d = DMAX; to = 1'b1; end
`endif
                to_flag = to_flag | to;
                q.push_back(mk(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0));
                q.push_back(mk(cyc + 2 + d, 1'b0, 1'b0, 1'b1, 1'b0, to_flag, 32'h0, epc, code[4:0]));
                q.push_back(mk(cyc + 3 + d, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {mtv[31:2], 2'b00}, 32'h0, 5'h0));
                for (int i = cyc + 1; i <= cyc + 3 + d; i++) exp_busy[i] = 1'b1;
                drain_lo = cyc + 2; drain_hi = cyc + 1 + d; busy_hi = cyc + 1 + n;
                free_at = cyc + 4 + d;
            end else if (m) begin
                q.push_back(mk(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'h0));
                q.push_back(mk(cyc + 2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, mep, 32'h0, 5'h0));
                exp_busy[cyc + 1] = 1'b1; exp_busy[cyc + 2] = 1'b1;
                free_at = cyc + 3;
            end else if (b) begin
                q.push_back(mk(cyc + 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, tgt, 32'h0, 5'h0));
                free_at = cyc + 1;
            end
        end
        if (cyc >= drain_lo && cyc <= drain_hi) mem_busy = (cyc <= busy_hi);
        else mem_busy = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 6'($urandom), $urandom, $urandom, $urandom, $urandom, 0);
    endtask

    initial begin
        rst = 1'b1;
        exc_valid = 0; mret_req = 0; br_jmp_flag = 0; mem_busy = 0;
        exc_code = '0; exc_pc = '0; br_target = '0; mtvec = '0; mepc_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_state", all_outs(), 96'(0));
        free_at = cyc;
        mon_en  = 1'b1;

        step(1'b1, 1'b0, 1'b0, 6'h22, 32'h100, 32'h0, 32'h8000_0003, 32'h0, 0);
        idle(6);
        step(1'b0, 1'b1, 1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 32'h244, 0);
        idle(4);
        step(1'b1, 1'b0, 1'b1, 6'h23, 32'h200, 32'h40, 32'h1000, 32'h0, 0);
        idle(7);
        step(1'b1, 1'b0, 1'b0, 6'h05, 32'h300, 32'h0, 32'h2000, 32'h0, 5);
        idle(12);
        step(1'b1, 1'b0, 1'b0, 6'h3f, 32'h340, 32'h0, 32'h2100, 32'h0, 6);
        idle(12);

        // Reset pulse while the controller sits in DRAIN.
        step(1'b1, 1'b0, 1'b0, 6'h2a, 32'h400, 32'h0, 32'h3000, 32'h0, 6);
        idle(2);
        #2 mon_en = 1'b0; rst = 1'b1;
        #1 check("reset_mid_drain", all_outs(), 96'(0));
        @(posedge clk); #1 rst = 1'b0;
        q.delete();
        for (int i = cyc; i < NCYC; i++) exp_busy[i] = 1'b0;
        free_at = cyc; drain_hi = -1; busy_hi = -1; to_flag = 1'b0;
        mon_en = 1'b1;
        step(1'b0, 1'b0, 1'b1, 6'h0, 32'h0, 32'h1234, 32'h0, 32'h0, 0);
        idle(3);

        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 4) == 0), 6'($urandom), $urandom, $urandom,
                 $urandom, $urandom, int'($urandom_range(0, 6)));
        idle(20);

        check("queue_empty", 96'(q.size()), 96'(0));
        check("drain_timeout_final", 96'(drain_timeout), 96'(to_flag));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
